lsu: RTL and testbench

Load-store unit for the RV32I core, sitting directly downstream of the ALU in the MEM stage. Takes the ALU result as the effective address and `rs2_data` as store data, performs byte/half/word accesses to an on-chip data memory and a small memory-mapped I/O window, and returns load data one cycle later. Misaligned or malformed accesses are suppressed and flagged instead of corrupting memory.

---
 rtl/lsu_if.sv | 21 ++
 rtl/lsu.sv | 191 +++++++++++++++++++
 tb/tb_lsu.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_if.sv
// Load/store request bus between the MEM stage and the load-store unit.
interface lsu_if;
  logic [31:0] addr;
  logic [31:0] st_data;
  logic        ld_en;
  logic        st_en;
  logic [2:0]  ls_op;
  logic [31:0] ld_data;
  logic        ld_valid;
  logic        misaligned;

  modport master (
    output addr, st_data, ld_en, st_en, ls_op,
    input  ld_data, ld_valid, misaligned
  );

  modport slave (
    input  addr, st_data, ld_en, st_en, ls_op,
    output ld_data, ld_valid, misaligned
  );
endinterface

// File: rtl/lsu.sv
// RV32I load-store unit: byte/half/word access to on-chip DMEM plus an
// optional memory-mapped I/O window (LEDR/LEDG/HEX_LO/HEX_HI, SW read-only).
// Define LSU_IO_EN to build the I/O window and the switch synchroniser.
// Load data is registered and appears one cycle after ld_en.
module lsu #(
  parameter int unsigned DMEM_WORDS = 2048
) (
  input  logic        clk,
  input  logic        rst,
  lsu_if.slave        bus,
  input  logic [31:0] io_sw,
  output logic [31:0] io_ledr,
  output logic [31:0] io_ledg,
  output logic [31:0] io_hex_lo,
  output logic [31:0] io_hex_hi
);
  localparam int unsigned AW        = $clog2(DMEM_WORDS);
  localparam logic [31:0] DMEM_BASE = 32'h0000_2000;

  typedef enum logic [2:0] {
    REG_NONE, REG_DMEM, REG_LEDR, REG_LEDG, REG_HEX_LO, REG_HEX_HI, REG_SW
  } region_t;

  logic [31:0]   mem [DMEM_WORDS];
  region_t       region;
  logic          op_ok, align_ok, mapped, good, fault;
  logic          do_load, do_store;
  logic [3:0]    be;
  logic [31:0]   wdata, rword, shifted, lval;
  logic [AW-1:0] widx;
  logic [31:0]   ld_data_q;
  logic          ld_valid_q, misaligned_q;

  assign widx = bus.addr[AW+1:2];

`ifdef LSU_IO_EN
  logic [31:0] ledr, ledg, hex_lo, hex_hi, sw_meta, sw_sync;
`endif

  // Address decode into a target region.
  always_comb begin
    region = REG_NONE;
    if ((bus.addr >> (AW + 2)) == (DMEM_BASE >> (AW + 2))) begin
      region = REG_DMEM;
    end
`ifdef LSU_IO_EN
    else begin
      case ({bus.addr[31:2], 2'b00})
        32'h0000_7000: region = REG_LEDR;
        32'h0000_7010: region = REG_LEDG;
        32'h0000_7020: region = REG_HEX_LO;
        32'h0000_7024: region = REG_HEX_HI;
        32'h0000_7800: region = REG_SW;
        default:       region = REG_NONE;
      endcase
    end
`endif
  end

  // Operation size, alignment check, byte enables and lane-replicated store data.
  always_comb begin
    op_ok    = 1'b1;
    align_ok = 1'b1;
    be       = '0;
    wdata    = bus.st_data;
    case (bus.ls_op)
      3'b000, 3'b100: begin
        be    = 4'b0001 << bus.addr[1:0];
        wdata = {4{bus.st_data[7:0]}};
      end
      3'b001, 3'b101: begin
        align_ok = ~bus.addr[0];
        be       = bus.addr[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{bus.st_data[15:0]}};
      end
      3'b010: begin
        align_ok = (bus.addr[1:0] == 2'b00);
        be       = '1;
      end
      default: op_ok = 1'b0;
    endcase
  end

  assign mapped   = (region != REG_NONE);
  assign good     = op_ok && mapped && align_ok;
  assign fault    = op_ok && mapped && !align_ok;
  assign do_load  = bus.ld_en && !bus.st_en;
  assign do_store = bus.st_en && good;

  // Read word selection and lane extraction with sign/zero extension.
  always_comb begin
    rword = '0;
    case (region)
      REG_DMEM:   rword = mem[widx];
`ifdef LSU_IO_EN
      REG_LEDR:   rword = ledr;
      REG_LEDG:   rword = ledg;
      REG_HEX_LO: rword = hex_lo;
      REG_HEX_HI: rword = hex_hi;
      REG_SW:     rword = sw_sync;
`endif
      default:    rword = '0;
    endcase
    shifted = rword >> {bus.addr[1:0], 3'b000};
    lval    = '0;
    if (good) begin
      case (bus.ls_op)
        3'b000:  lval = {{24{shifted[7]}}, shifted[7:0]};
        3'b100:  lval = {24'h0, shifted[7:0]};
        3'b001:  lval = {{16{shifted[15]}}, shifted[15:0]};
        3'b101:  lval = {16'h0, shifted[15:0]};
        default: lval = rword;
      endcase
    end
  end

  // Byte-enabled DMEM write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (do_store && region == REG_DMEM) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Registered load result and one-cycle status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_data_q    <= '0;
      ld_valid_q   <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      ld_valid_q   <= do_load;
      misaligned_q <= (bus.ld_en || bus.st_en) && fault;
      if (do_load) ld_data_q <= lval;
    end
  end

  assign bus.ld_data    = ld_data_q;
  assign bus.ld_valid   = ld_valid_q;
  assign bus.misaligned = misaligned_q;

`ifdef LSU_IO_EN
  function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                              input logic [31:0] nxt,
                                              input logic [3:0]  en);
    logic [31:0] r;
    r = cur;
    for (int unsigned i = 0; i < 4; i++) begin
      if (en[i]) r[8*i +: 8] = nxt[8*i +: 8];
    end
    return r;
  endfunction

  // I/O output registers with byte enables, plus the 2-flop switch synchroniser.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ledr    <= '0;
      ledg    <= '0;
      hex_lo  <= '0;
      hex_hi  <= '0;
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= io_sw;
      sw_sync <= sw_meta;
      if (do_store) begin
        case (region)
          REG_LEDR:   ledr   <= merge_bytes(ledr, wdata, be);
          REG_LEDG:   ledg   <= merge_bytes(ledg, wdata, be);
          REG_HEX_LO: hex_lo <= merge_bytes(hex_lo, wdata, be);
          REG_HEX_HI: hex_hi <= merge_bytes(hex_hi, wdata, be);
          default:    ;
        endcase
      end
    end
  end

  assign io_ledr   = ledr;
  assign io_ledg   = ledg;
  assign io_hex_lo = hex_lo;
  assign io_hex_hi = hex_hi;
`else
  logic unused_sw;
  assign unused_sw = ^io_sw;
  assign io_ledr   = '0;
  assign io_ledg   = '0;
  assign io_hex_lo = '0;
  assign io_hex_hi = '0;
`endif
endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed vector table, I/O and reset sequences, then
// randomized traffic checked against a byte-addressed reference model.
module tb_lsu;
`ifdef LSU_IO_EN
  localparam bit IO_EN = 1'b1;
`else
  localparam bit IO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] io_sw = '0;
  logic [31:0] io_ledr, io_ledg, io_hex_lo, io_hex_hi;

  lsu_if bus();

  lsu #(.DMEM_WORDS(2048)) dut (
    .clk(clk), .rst(rst), .bus(bus), .io_sw(io_sw),
    .io_ledr(io_ledr), .io_ledg(io_ledg), .io_hex_lo(io_hex_lo), .io_hex_hi(io_hex_hi)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: memory as individual bytes, switch delay line, held load value.
  logic [7:0]  mb [int unsigned];
  logic [31:0] sw_d1, sw_d2, m_hold;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h", name, got, exp);
    end
  endtask

  function automatic bit m_mapped(input logic [31:0] a);
    if (a >= 32'h2000 && a <= 32'h3FFF) return 1'b1;
    if (IO_EN) begin
      case ({a[31:2], 2'b00})
        32'h7000, 32'h7010, 32'h7020, 32'h7024, 32'h7800: return 1'b1;
        default: ;
      endcase
    end
    return 1'b0;
  endfunction

  function automatic logic [7:0] m_rd_byte(input logic [31:0] a);
    logic [31:0] w;
    if ({a[31:2], 2'b00} == 32'h7800) begin
      w = sw_d2;
      return w[8*a[1:0] +: 8];
    end
    if (mb.exists(a)) return mb[a];
    return 8'h00;
  endfunction

  function automatic logic [31:0] m_io_word(input logic [31:0] base);
    if (!IO_EN) return 32'h0;
    return {m_rd_byte(base + 3), m_rd_byte(base + 2), m_rd_byte(base + 1), m_rd_byte(base)};
  endfunction

  task automatic m_reset();
    logic [31:0] bases [4];
    bases = '{32'h7000, 32'h7010, 32'h7020, 32'h7024};
    foreach (bases[i]) for (int unsigned k = 0; k < 4; k++) mb[bases[i] + k] = 8'h00;
    sw_d1  = '0;
    sw_d2  = '0;
    m_hold = '0;
  endtask

  // One access per cycle: drive at negedge, check everything #1 after the posedge.
  task automatic do_op(input logic ld, input logic st, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] gl, output logic gv, output logic gm);
    logic legal, mapped, mis, ok, ev, em;
    int unsigned sz;
    logic [31:0] val;
    @(negedge clk);
    bus.ld_en = ld; bus.st_en = st; bus.ls_op = op; bus.addr = a; bus.st_data = d;
    legal  = op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    sz     = 1 << op[1:0];
    mapped = m_mapped(a);
    mis    = legal && mapped && (a % sz != 0);
    ok     = legal && mapped && !mis;
    ev     = ld && !st;
    em     = (ld || st) && mis;
    if (ev) begin
      val = '0;
      if (ok) begin
        for (int unsigned k = 0; k < sz; k++) val[8*k +: 8] = m_rd_byte(a + k);
        if (!op[2] && sz < 4 && val[8*sz-1]) val = val | (32'hFFFF_FFFF << (8*sz));
      end
      m_hold = val;
    end
    if (st && ok && {a[31:2], 2'b00} != 32'h7800) begin
      for (int unsigned k = 0; k < sz; k++) mb[a + k] = d[8*k +: 8];
    end
    @(posedge clk);
    sw_d2 = sw_d1;
    sw_d1 = io_sw;
    #1;
    gl = bus.ld_data; gv = bus.ld_valid; gm = bus.misaligned;
    check("ld_data", gl, m_hold);
    check("ld_valid", {31'b0, gv}, {31'b0, ev});
    check("misaligned", {31'b0, gm}, {31'b0, em});
    check("io_ledr", io_ledr, m_io_word(32'h7000));
    check("io_ledg", io_ledg, m_io_word(32'h7010));
    check("io_hex_lo", io_hex_lo, m_io_word(32'h7020));
    check("io_hex_hi", io_hex_hi, m_io_word(32'h7024));
  endtask

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] e_ld;
    logic        e_v;
    logic        e_m;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic ld, input logic st, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] e_ld, input logic e_v, input logic e_m);
    vec_t v;
    v.ld = ld; v.st = st; v.op = op; v.addr = a; v.data = d;
    v.e_ld = e_ld; v.e_v = e_v; v.e_m = e_m;
    tv.push_back(v);
  endtask

  initial begin
    logic [31:0] gl;
    logic gv, gm;
    logic [31:0] a, d;
    logic [2:0] op;
    logic ld, st;
    int unsigned r;

    bus.ld_en = 1'b0; bus.st_en = 1'b0; bus.ls_op = 3'b010; bus.addr = '0; bus.st_data = '0;
    m_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst ld_data", bus.ld_data, 32'h0);
    check("rst ld_valid", {31'b0, bus.ld_valid}, 32'h0);
    check("rst misaligned", {31'b0, bus.misaligned}, 32'h0);
    check("rst io_ledr", io_ledr, 32'h0);
    check("rst io_hex_hi", io_hex_hi, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    //  ld    st    op      addr          data          e_ld          v     m
    add(1'b0, 1'b1, 3'd2, 32'h2000, 32'hDEADBEEF, 32'h00000000, 1'b0, 1'b0);
    add(1'b1, 1'b0, 3'd2, 32'h2000, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0);
    add(1'b0, 1'b1, 3'd0, 32'h2001, 32'h00000080, 32'hDEADBEEF, 1'b0, 1'b0);
    add(1'b1, 1'b0, 3'd0, 32'h2001, 32'h0,        32'hFFFFFF80, 1'b1, 1'b0);
    add(1'b1, 1'b0, 3'd4, 32'h2001, 32'h0,        32'h00000080, 1'b1, 1'b0);
    add(1'b1, 1'b0, 3'd2, 32'h2000, 32'h0,        32'hDEAD80EF, 1'b1, 1'b0);
    add(1'b0, 1'b1, 3'd1, 32'h2003, 32'h00001234, 32'hDEAD80EF, 1'b0, 1'b1);
    add(1'b1, 1'b0, 3'd2, 32'h2002, 32'h0,        32'h00000000, 1'b1, 1'b1);
    add(1'b1, 1'b0, 3'd2, 32'h2000, 32'h0,        32'hDEAD80EF, 1'b1, 1'b0);
    add(1'b1, 1'b0, 3'd1, 32'h2002, 32'h0,        32'hFFFFDEAD, 1'b1, 1'b0);
    add(1'b1, 1'b0, 3'd5, 32'h2002, 32'h0,        32'h0000DEAD, 1'b1, 1'b0);
    add(1'b1, 1'b0, 3'd2, 32'h5000, 32'h0,        32'h00000000, 1'b1, 1'b0);
    add(1'b1, 1'b0, 3'd3, 32'h2000, 32'h0,        32'h00000000, 1'b1, 1'b0);
    add(1'b0, 1'b1, 3'd7, 32'h2000, 32'h0,        32'h00000000, 1'b0, 1'b0);
    add(1'b1, 1'b0, 3'd2, 32'h2000, 32'h0,        32'hDEAD80EF, 1'b1, 1'b0);
    add(1'b1, 1'b1, 3'd2, 32'h2004, 32'h11111111, 32'hDEAD80EF, 1'b0, 1'b0);
    add(1'b1, 1'b0, 3'd2, 32'h2004, 32'h0,        32'h11111111, 1'b1, 1'b0);
    add(1'b1, 1'b0, 3'd1, 32'h2001, 32'h0,        32'h00000000, 1'b1, 1'b1);
    add(1'b0, 1'b1, 3'd2, 32'h3FFC, 32'hCAFEF00D, 32'h00000000, 1'b0, 1'b0);
    add(1'b1, 1'b0, 3'd2, 32'h3FFC, 32'h0,        32'hCAFEF00D, 1'b1, 1'b0);
    add(1'b1, 1'b0, 3'd2, 32'h4000, 32'h0,        32'h00000000, 1'b1, 1'b0);
    add(1'b1, 1'b0, 3'd2, 32'h1FFC, 32'h0,        32'h00000000, 1'b1, 1'b0);
    add(1'b1, 1'b0, 3'd0, 32'h3FFF, 32'h0,        32'hFFFFFFCA, 1'b1, 1'b0);
    add(1'b1, 1'b0, 3'd5, 32'h3FFE, 32'h0,        32'h0000CAFE, 1'b1, 1'b0);

    foreach (tv[i]) begin
      do_op(tv[i].ld, tv[i].st, tv[i].op, tv[i].addr, tv[i].data, gl, gv, gm);
      check($sformatf("vec%0d ld_data", i), gl, tv[i].e_ld);
      check($sformatf("vec%0d ld_valid", i), {31'b0, gv}, {31'b0, tv[i].e_v});
      check($sformatf("vec%0d misaligned", i), {31'b0, gm}, {31'b0, tv[i].e_m});
    end

    // I/O window writes and read-back
    do_op(1'b0, 1'b1, 3'd2, 32'h7000, 32'h12345678, gl, gv, gm);
    check("io ledr word", io_ledr, IO_EN ? 32'h12345678 : 32'h0);
    do_op(1'b0, 1'b1, 3'd0, 32'h7021, 32'h000000AA, gl, gv, gm);
    check("io hex_lo lane1", {24'h0, io_hex_lo[15:8]}, IO_EN ? 32'hAA : 32'h0);
    check("io hex_lo rest", {io_hex_lo[31:16], 8'h00, io_hex_lo[7:0]}, 32'h0);
    do_op(1'b1, 1'b0, 3'd2, 32'h7000, 32'h0, gl, gv, gm);
    check("io ledr load", gl, IO_EN ? 32'h12345678 : 32'h0);
    do_op(1'b1, 1'b0, 3'd4, 32'h7021, 32'h0, gl, gv, gm);
    check("io hex_lo lbu", gl, IO_EN ? 32'hAA : 32'h0);
    do_op(1'b0, 1'b1, 3'd2, 32'h7800, 32'hFFFFFFFF, gl, gv, gm);

    // Switch synchroniser latency
    io_sw = 32'h0000_00F0;
    do_op(1'b1, 1'b0, 3'd2, 32'h7800, 32'h0, gl, gv, gm);
    check("sw cycle1 old", gl, 32'h0);
    do_op(1'b0, 1'b0, 3'd2, 32'h2000, 32'h0, gl, gv, gm);
    do_op(1'b1, 1'b0, 3'd2, 32'h7800, 32'h0, gl, gv, gm);
    check("sw cycle3 new", gl, IO_EN ? 32'h000000F0 : 32'h0);

    // Reset in the middle of a misaligned load, with a load pulse outstanding
    do_op(1'b1, 1'b0, 3'd2, 32'h2000, 32'h0, gl, gv, gm);
    @(negedge clk);
    bus.ld_en = 1'b1; bus.st_en = 1'b0; bus.ls_op = 3'd2; bus.addr = 32'h2002;
    #2 rst = 1'b1;
    #1;
    check("midrst ld_data", bus.ld_data, 32'h0);
    check("midrst ld_valid", {31'b0, bus.ld_valid}, 32'h0);
    check("midrst misaligned", {31'b0, bus.misaligned}, 32'h0);
    check("midrst io_ledr", io_ledr, 32'h0);
    check("midrst io_hex_lo", io_hex_lo, 32'h0);
    @(posedge clk);
    #1;
    check("midrst pulse cancelled", {30'b0, bus.ld_valid, bus.misaligned}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.ld_en = 1'b0;
    m_reset();
    do_op(1'b1, 1'b0, 3'd2, 32'h2000, 32'h0, gl, gv, gm);
    check("dmem survives reset", gl, 32'hDEAD80EF);

    // Randomized traffic: prefill a DMEM window, then mixed accesses
    for (int unsigned w = 0; w < 64; w++)
      do_op(1'b0, 1'b1, 3'd2, 32'h2000 + 4*w, $urandom, gl, gv, gm);
    for (int n = 0; n < 500; n++) begin
      r = $urandom_range(99);
      if (r < 70)      a = 32'h2000 + $urandom_range(255);
      else if (r < 85) begin
        case ($urandom_range(5))
          0: a = 32'h7000; 1: a = 32'h7010; 2: a = 32'h7020;
          3: a = 32'h7024; 4: a = 32'h7800; default: a = 32'h7004;
        endcase
        a[1:0] = 2'($urandom_range(3));
      end
      else if (r < 92) a = 32'h3F00 + $urandom_range(255);
      else             a = 32'h4000 + 32'($urandom_range(32'hFFF));
      if (!m_mapped(a)) a[1:0] = 2'b00;
      op = 3'($urandom_range(7));
      r  = $urandom_range(99);
      ld = (r < 45) || (r >= 75 && r < 85);
      st = (r >= 45 && r < 85);
      d  = $urandom;
      if ($urandom_range(9) == 0) io_sw = $urandom;
      do_op(ld, st, op, a, d, gl, gv, gm);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
